// File: rtl/weighted_window_voter.sv
// weighted_window_voter
//   Weighted majority voter over N_CH redundant bit-streams, evaluated over a
//   sliding window of the last WIN_LEN samples. Three-stage pipeline:
//     stage 1: weighted sum of the current sample
//     stage 2: ring buffer + running window accumulator
//     stage 3: decision (auto-majority or explicit threshold) and outputs
//   Optional macro VOTE_HYST_EN: vote_out flips only after HYST_CNT
//   consecutive differing decisions.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sample_en, din      sample strobe and one bit per channel
//   mode, thresh        0 = auto-majority, 1 = acc >= thresh
//   clear               synchronous window flush
//   cfg_we/addr/wdata   per-channel weight write (valid address also flushes)
//   vote_out            registered decision
//   vote_valid          one-cycle pulse per evaluation
//   win_full            window holds WIN_LEN samples
//   acc_out             current window sum
//   disagree            channels whose evaluated sample differs from vote_out
module weighted_window_voter #(
  parameter int N_CH     = 3,
  parameter int W_BITS   = 4,
  parameter int WIN_LEN  = 4,
  parameter int HYST_CNT = 2,
  localparam int SUM_W   = W_BITS + $clog2(N_CH + 1),
  localparam int ACC_W   = SUM_W + $clog2(WIN_LEN + 1),
  localparam int AW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic [N_CH-1:0]   din,
  input  logic              mode,
  input  logic [ACC_W-1:0]  thresh,
  input  logic              clear,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [W_BITS-1:0] cfg_wdata,
  output logic              vote_out,
  output logic              vote_valid,
  output logic              win_full,
  output logic [ACC_W-1:0]  acc_out,
  output logic [N_CH-1:0]   disagree
);

  localparam int FW    = $clog2(WIN_LEN + 1);
  localparam int PW    = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int CMP_W = ACC_W + 1;

  // Parameter sanity checks, evaluated at elaboration only.
  if (N_CH < 1 || WIN_LEN < 1 || HYST_CNT < 1) begin : g_param_check
    $error("weighted_window_voter: N_CH, WIN_LEN and HYST_CNT must be >= 1");
  end

  // ------------------------------------------------------------------
  // Weights and flush
  // ------------------------------------------------------------------
  logic                          addr_ok;
  logic                          flush;
  logic [N_CH-1:0][W_BITS-1:0]   weight;

  assign addr_ok = (32'(cfg_addr) < 32'(N_CH));
  // A weight change flushes the window so every stored sum was produced
  // with the same weight set that wtot describes.
  assign flush   = clear | (cfg_we & addr_ok);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_weight
    logic [W_BITS-1:0] w_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        w_reg <= W_BITS'(1);
      end else if (cfg_we && cfg_addr == AW'(gi)) begin
        w_reg <= cfg_wdata;
      end
    end
    assign weight[gi] = w_reg;
  end

  logic [SUM_W-1:0] s1_next;
  logic [SUM_W-1:0] wtot;

  always_comb begin
    s1_next = '0;
    wtot    = '0;
    for (int i = 0; i < N_CH; i++) begin
      wtot = wtot + SUM_W'(weight[i]);
      if (din[i]) begin
        s1_next = s1_next + SUM_W'(weight[i]);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 1: weighted sample sum
  // ------------------------------------------------------------------
  logic [SUM_W-1:0] s1_reg;
  logic [N_CH-1:0]  din1_reg;
  logic             v1_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg   <= '0;
      din1_reg <= '0;
      v1_reg   <= 1'b0;
    end else if (flush) begin
      v1_reg   <= 1'b0;
    end else begin
      v1_reg <= sample_en;
      if (sample_en) begin
        s1_reg   <= s1_next;
        din1_reg <= din;
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: ring buffer and running window sum
  // ------------------------------------------------------------------
  logic [SUM_W-1:0] ring_reg [WIN_LEN];
  logic [PW-1:0]    wr_ptr_reg;
  logic [FW-1:0]    fill_reg;
  logic [FW-1:0]    fill_next;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;
  logic [SUM_W-1:0] evicted;
  logic [N_CH-1:0]  din2_reg;
  logic             v2_reg;
  logic             full;

  assign full = (fill_reg == FW'(WIN_LEN));

  always_comb begin
    // Until the window has wrapped, the slot being overwritten holds no sample.
    evicted   = full ? ring_reg[wr_ptr_reg] : '0;
    acc_next  = acc_reg + ACC_W'(s1_reg) - ACC_W'(evicted);
    fill_next = full ? fill_reg : fill_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN_LEN; i++) ring_reg[i] <= '0;
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      acc_reg    <= '0;
      din2_reg   <= '0;
      v2_reg     <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < WIN_LEN; i++) ring_reg[i] <= '0;
      wr_ptr_reg <= '0;
      fill_reg   <= '0;
      acc_reg    <= '0;
      v2_reg     <= 1'b0;
    end else if (v1_reg) begin
      ring_reg[wr_ptr_reg] <= s1_reg;
      wr_ptr_reg <= (wr_ptr_reg == PW'(WIN_LEN - 1)) ? '0 : wr_ptr_reg + 1'b1;
      fill_reg   <= fill_next;
      acc_reg    <= acc_next;
      din2_reg   <= din1_reg;
      v2_reg     <= 1'b1;
    end else begin
      v2_reg     <= 1'b0;
    end
  end

  assign acc_out  = acc_reg;
  assign win_full = full;

  // ------------------------------------------------------------------
  // Stage 3: decision
  // ------------------------------------------------------------------
  logic [CMP_W-1:0] lhs;
  logic [CMP_W-1:0] rhs;
  logic             decision;
  logic             is_tie;
  logic             vote_next;
  logic             vote_out_reg;
  logic             vote_valid_reg;
  logic [N_CH-1:0]  disagree_reg;

  always_comb begin
    // Majority without division: 2*acc vs fill*wtot, exact at full width.
    lhs      = {acc_reg, 1'b0};
    rhs      = CMP_W'(fill_reg) * CMP_W'(wtot);
    is_tie   = !mode && (lhs == rhs);
    decision = mode ? (acc_reg >= thresh) : (lhs > rhs);
  end

`ifdef VOTE_HYST_EN
  localparam int HW = $clog2(HYST_CNT + 1);
  logic [HW-1:0] hyst_reg;
  logic [HW-1:0] hyst_next;

  always_comb begin
    vote_next = vote_out_reg;
    hyst_next = '0;
    if (!is_tie && decision != vote_out_reg) begin
      if (hyst_reg == HW'(HYST_CNT - 1)) begin
        vote_next = decision;
        hyst_next = '0;
      end else begin
        hyst_next = hyst_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hyst_reg <= '0;
    end else if (flush) begin
      hyst_reg <= '0;
    end else if (v2_reg) begin
      hyst_reg <= hyst_next;
    end
  end
`else
  always_comb begin
    vote_next = is_tie ? vote_out_reg : decision;
  end
`endif

  // A flush edge suppresses evaluation: vote_out and disagree hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vote_out_reg   <= 1'b0;
      vote_valid_reg <= 1'b0;
      disagree_reg   <= '0;
    end else if (flush) begin
      vote_valid_reg <= 1'b0;
    end else if (v2_reg) begin
      vote_out_reg   <= vote_next;
      vote_valid_reg <= 1'b1;
      disagree_reg   <= din2_reg ^ {N_CH{vote_next}};
    end else begin
      vote_valid_reg <= 1'b0;
    end
  end

  assign vote_out   = vote_out_reg;
  assign vote_valid = vote_valid_reg;
  assign disagree   = disagree_reg;

endmodule

// File: tb/tb_weighted_window_voter.sv
// Directed testbench for weighted_window_voter at default parameters
// (N_CH=3, W_BITS=4, WIN_LEN=4, VOTE_HYST_EN undefined).
module tb_weighted_window_voter;

  localparam int N_CH   = 3;
  localparam int W_BITS = 4;
  localparam int ACC_W  = 9;
  localparam int AW     = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_en;
  logic [N_CH-1:0]   din;
  logic              mode;
  logic [ACC_W-1:0]  thresh;
  logic              clear;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [W_BITS-1:0] cfg_wdata;
  logic              vote_out;
  logic              vote_valid;
  logic              win_full;
  logic [ACC_W-1:0]  acc_out;
  logic [N_CH-1:0]   disagree;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  weighted_window_voter dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .din        (din),
    .mode       (mode),
    .thresh     (thresh),
    .clear      (clear),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .vote_out   (vote_out),
    .vote_valid (vote_valid),
    .win_full   (win_full),
    .acc_out    (acc_out),
    .disagree   (disagree)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input logic [AW-1:0] a, input logic [W_BITS-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  // Present one sample, then idle until its evaluation edge (k+2).
  task automatic one_sample(input logic [N_CH-1:0] d);
    sample_en = 1'b1;
    din       = d;
    tick();
    sample_en = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; din = '0; mode = 1'b0; thresh = '0;
    clear = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    tick();
    tick();
    check("rst_vote", vote_out, 0);
    check("rst_valid", vote_valid, 0);
    check("rst_full", win_full, 0);
    check("rst_acc", acc_out, 0);
    check("rst_disagree", disagree, 0);
    rst = 1'b0;
    tick();

    // Unequal weights, stream 111, then async reset mid-stream.
    write_w(2'd0, 4'd0);
    sample_en = 1'b1; din = 3'b111;
    tick(); tick(); tick();
    check("pre_rst_vote", vote_out, 1);
    check("pre_rst_acc", acc_out, 4);
    #2 rst = 1'b1;
    #1;
    check("async_rst_vote", vote_out, 0);
    check("async_rst_acc", acc_out, 0);
    check("async_rst_valid", vote_valid, 0);
    sample_en = 1'b0; din = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Equal weights restored: one sample 011.
    one_sample(3'b011);
    check("maj_acc", acc_out, 2);
    check("maj_vote", vote_out, 1);
    check("maj_valid", vote_valid, 1);
    check("maj_disagree", disagree, 3'b100);
    check("maj_full", win_full, 0);
    tick();
    check("maj_valid_pulse", vote_valid, 0);

    // Weights {1,1,5}, stream 011 x4.
    write_w(2'd2, 4'd5);
    check("w_flush_acc", acc_out, 0);
    check("w_flush_vote_hold", vote_out, 1);
    sample_en = 1'b1; din = 3'b011;
    tick(); tick(); tick(); tick();
    sample_en = 1'b0;
    tick(); tick();
    check("w5_acc", acc_out, 8);
    check("w5_full", win_full, 1);
    check("w5_vote", vote_out, 0);
    check("w5_valid", vote_valid, 1);
    check("w5_disagree", disagree, 3'b011);

    // Slide and tie with equal weights.
    write_w(2'd2, 4'd1);
    one_sample(3'b111); check("slide_acc1", acc_out, 3);
    one_sample(3'b111); check("slide_acc2", acc_out, 6);
    one_sample(3'b111); check("slide_acc3", acc_out, 9);
    one_sample(3'b111); check("slide_acc4", acc_out, 12);
    check("slide_vote4", vote_out, 1);
    one_sample(3'b000); check("slide_acc9", acc_out, 9);
    check("slide_vote9", vote_out, 1);
    check("slide_dis9", disagree, 3'b111);
    one_sample(3'b000); check("tie_acc", acc_out, 6);
    check("tie_vote_hold", vote_out, 1);
    check("tie_valid", vote_valid, 1);
    one_sample(3'b000); check("slide_acc3b", acc_out, 3);
    check("slide_vote_low", vote_out, 0);

    // Threshold mode.
    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_acc", acc_out, 0);
    mode = 1'b1; thresh = 9'd5;
    one_sample(3'b001); check("thr_acc1", acc_out, 1);
    one_sample(3'b001); check("thr_acc2", acc_out, 2);
    one_sample(3'b001); check("thr_acc3", acc_out, 3);
    one_sample(3'b001); check("thr_acc4", acc_out, 4);
    check("thr_full", win_full, 1);
    one_sample(3'b001); check("thr_acc4b", acc_out, 4);
    check("thr_vote_low", vote_out, 0);
    one_sample(3'b011); check("thr_acc5", acc_out, 5);
    check("thr_vote_high", vote_out, 1);
    check("thr_disagree", disagree, 3'b100);

    // Flush from a weight write collides with a sample.
    mode = 1'b0;
    sample_en = 1'b1; din = 3'b000;
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 4'd1;
    tick();
    sample_en = 1'b0; cfg_we = 1'b0;
    check("flush_acc", acc_out, 0);
    check("flush_full", win_full, 0);
    tick();
    check("flush_no_valid1", vote_valid, 0);
    tick();
    check("flush_no_valid2", vote_valid, 0);
    check("flush_vote_hold", vote_out, 1);
    check("flush_dis_hold", disagree, 3'b100);

    // Out-of-range address: no flush, no weight change.
    one_sample(3'b111); check("oob_pre_acc", acc_out, 3);
    write_w(2'd3, 4'd9);
    check("oob_acc_kept", acc_out, 3);
    one_sample(3'b111); check("oob_acc", acc_out, 6);
    check("oob_valid", vote_valid, 1);
    check("oob_vote", vote_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
